// File: rtl/dsp_xintf_regbank.sv
// XINTF (async SRAM style) register bank: N_REGS control registers, sticky fault latch with mask/IRQ, ID word.
// Optional write lock register enabled by defining XINTF_WRITE_LOCK_EN.
module dsp_xintf_regbank #(
  parameter int unsigned       ADDR_W           = 14,
  parameter int unsigned       DATA_W           = 16,
  parameter int unsigned       N_REGS           = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR        = 14'h0010,
  parameter int unsigned       FAULT_W          = 8,
  parameter bit                FAULT_ACTIVE_LOW = 1'b1,
  parameter logic [DATA_W-1:0] ID_VALUE         = 16'h4000
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        Addr,
  inout  wire logic [DATA_W-1:0]   Data,
  input  logic                     CSn,
  input  logic                     WEn,
  input  logic                     OEn,
  input  logic [FAULT_W-1:0]       FAULT_INPUT,
  output logic [N_REGS*DATA_W-1:0] CTRL_OUT,
  output logic                     WR_STROBE,
  output logic [4:0]               WR_INDEX,
  output logic                     FAULT_XINT
);

  localparam logic [ADDR_W-1:0]  OFF_FLT    = ADDR_W'(N_REGS);
  localparam logic [ADDR_W-1:0]  OFF_MASK   = ADDR_W'(N_REGS + 1);
  localparam logic [ADDR_W-1:0]  OFF_ID     = ADDR_W'(N_REGS + 2);
  localparam logic [FAULT_W-1:0] FAULT_IDLE = FAULT_ACTIVE_LOW ? '1 : '0;

  logic                     csn_s1, csn_s2, wen_s1, wen_s2, oen_s1, oen_s2;
  logic [1:0]               sync_live;
  logic                     wr_armed;
  logic [ADDR_W-1:0]        addr_q, off;
  logic [DATA_W-1:0]        data_q, rd_mux, rd_buf;
  logic [N_REGS*DATA_W-1:0] ctrl_q;
  logic [FAULT_W-1:0]       fault_s1, fault_s2, fault_set, fault_clr, latch, mask;
  logic                     commit, wr_allow, wr_ctrl;

  // wen_s2 only reflects a real sample once sync_live[1] is set; arming on a
  // genuine high WEn keeps a strobe that straddles reset from committing.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      {csn_s1, csn_s2, wen_s1, wen_s2, oen_s1, oen_s2} <= '1;
      sync_live <= '0;
      wr_armed  <= 1'b0;
      fault_s1  <= FAULT_IDLE;
      fault_s2  <= FAULT_IDLE;
    end else begin
      csn_s1    <= CSn;  csn_s2 <= csn_s1;
      wen_s1    <= WEn;  wen_s2 <= wen_s1;
      oen_s1    <= OEn;  oen_s2 <= oen_s1;
      sync_live <= {sync_live[0], 1'b1};
      if (sync_live[1] && wen_s2) wr_armed <= 1'b1;
      fault_s1  <= FAULT_INPUT;
      fault_s2  <= fault_s1;
    end
  end

  assign commit    = wr_armed && !wen_s2 && wen_s1 && !csn_s2;
  assign off       = addr_q - BASE_ADDR;
  assign wr_ctrl   = commit && wr_allow && (off < OFF_FLT);
  assign fault_set = FAULT_ACTIVE_LOW ? ~fault_s2 : fault_s2;
  assign fault_clr = (commit && off == OFF_FLT) ? data_q[FAULT_W-1:0] : '0;
  assign CTRL_OUT  = ctrl_q;

`ifdef XINTF_WRITE_LOCK_EN
  localparam logic [ADDR_W-1:0] OFF_LOCK = ADDR_W'(N_REGS + 3);
  logic unlocked;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) unlocked <= 1'b0;
    else if (commit && off == OFF_LOCK) unlocked <= (data_q == DATA_W'(16'hA55A));
  end
  assign wr_allow = unlocked;
`else
  assign wr_allow = 1'b1;
`endif

  // Address is captured for reads too, so the read mux sees the current address.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      addr_q <= '0;
      data_q <= '0;
      rd_buf <= '0;
    end else begin
      if (!csn_s1 && (!wen_s1 || !oen_s1)) addr_q <= Addr;
      if (!csn_s1 && !wen_s1) data_q <= Data;
      if (!csn_s2 && !oen_s2) rd_buf <= rd_mux;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ctrl_q     <= '0;
      WR_STROBE  <= 1'b0;
      WR_INDEX   <= '0;
      latch      <= '0;
      mask       <= '1;
      FAULT_XINT <= 1'b0;
    end else begin
      WR_STROBE <= wr_ctrl;
      if (wr_ctrl) WR_INDEX <= off[4:0];
      for (int unsigned k = 0; k < N_REGS; k++) begin
        if (wr_ctrl && off == ADDR_W'(k)) ctrl_q[k*DATA_W +: DATA_W] <= data_q;
      end
      if (commit && off == OFF_MASK) mask <= data_q[FAULT_W-1:0];
      latch      <= (latch & ~fault_clr) | fault_set;
      FAULT_XINT <= |(latch & mask);
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      if (off == ADDR_W'(k)) rd_mux = ctrl_q[k*DATA_W +: DATA_W];
    end
    if (off == OFF_FLT)  rd_mux = DATA_W'(latch);
    if (off == OFF_MASK) rd_mux = DATA_W'(mask);
    if (off == OFF_ID)   rd_mux = ID_VALUE | DATA_W'(N_REGS);
`ifdef XINTF_WRITE_LOCK_EN
    if (off == OFF_LOCK) rd_mux = DATA_W'(unlocked);
`endif
  end

  assign Data = (!CSn && !OEn) ? rd_buf : 'z;

endmodule

// File: tb/tb_dsp_xintf_regbank.sv
// Directed, table-driven bench for dsp_xintf_regbank (default parameters, BASE=0x10, N_REGS=8).
module tb_dsp_xintf_regbank;

  localparam logic [13:0] A_FLT  = 14'h0018;
  localparam logic [13:0] A_MASK = 14'h0019;
  localparam logic [13:0] A_ID   = 14'h001A;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [13:0]  Addr = '0;
  wire  [15:0]  Data;
  logic [15:0]  drv = '0;
  logic         drv_en = 1'b0;
  logic         CSn = 1'b1, WEn = 1'b1, OEn = 1'b1;
  logic [7:0]   FAULT_INPUT = 8'hFF;
  logic [127:0] CTRL_OUT;
  logic         WR_STROBE;
  logic [4:0]   WR_INDEX;
  logic         FAULT_XINT;

  assign Data = drv_en ? drv : 'z;

  dsp_xintf_regbank dut (
    .CLK(CLK), .RESET(RESET), .Addr(Addr), .Data(Data), .CSn(CSn), .WEn(WEn), .OEn(OEn),
    .FAULT_INPUT(FAULT_INPUT), .CTRL_OUT(CTRL_OUT), .WR_STROBE(WR_STROBE),
    .WR_INDEX(WR_INDEX), .FAULT_XINT(FAULT_XINT)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int strobes = 0;
  logic [4:0] last_idx = '0;
  logic watch_xint = 1'b0;
  logic xint_dropped = 1'b0;

  always @(negedge CLK) begin
    if (WR_STROBE) begin
      strobes  <= strobes + 1;
      last_idx <= WR_INDEX;
    end
    if (watch_xint && !FAULT_XINT) xint_dropped <= 1'b1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [13:0] a, input logic [15:0] d, input int hold);
    @(negedge CLK);
    Addr = a; drv = d; drv_en = 1'b1; CSn = 1'b0; WEn = 1'b0;
    repeat (hold) @(negedge CLK);
    WEn = 1'b1; CSn = 1'b1;
    repeat (4) @(negedge CLK);
    drv_en = 1'b0;
  endtask

  task automatic bus_read(input logic [13:0] a, output logic [15:0] d);
    @(negedge CLK);
    Addr = a; CSn = 1'b0; OEn = 1'b0;
    repeat (4) @(posedge CLK);
    #1 d = Data;
    @(negedge CLK);
    CSn = 1'b1; OEn = 1'b1;
    repeat (2) @(negedge CLK);
  endtask

  typedef struct {
    bit          wr;
    logic [13:0] addr;
    logic [15:0] data;
    bit          strobe;
    logic [4:0]  idx;
    string       name;
  } vec_t;

  vec_t vecs[18];

  initial begin
    logic [15:0] rd;
    int s0;
    int lat;

    vecs[0]  = '{1'b1, 14'h0010, 16'hA5A5, 1'b1, 5'd0, "wr_reg0"};
    vecs[1]  = '{1'b1, 14'h0017, 16'hFFFF, 1'b1, 5'd7, "wr_reg7"};
    vecs[2]  = '{1'b1, 14'h0015, 16'h0F0F, 1'b1, 5'd5, "wr_reg5"};
    vecs[3]  = '{1'b1, A_ID,     16'hBEEF, 1'b0, 5'd0, "wr_id_ignored"};
    vecs[4]  = '{1'b1, 14'h0030, 16'h1111, 1'b0, 5'd0, "wr_unmapped_hi"};
    vecs[5]  = '{1'b1, 14'h000F, 16'h2222, 1'b0, 5'd0, "wr_unmapped_lo"};
    vecs[6]  = '{1'b0, 14'h0010, 16'hA5A5, 1'b0, 5'd0, "rd_reg0"};
    vecs[7]  = '{1'b0, 14'h0017, 16'hFFFF, 1'b0, 5'd0, "rd_reg7"};
    vecs[8]  = '{1'b0, 14'h0015, 16'h0F0F, 1'b0, 5'd0, "rd_reg5"};
    vecs[9]  = '{1'b0, 14'h0013, 16'h1234, 1'b0, 5'd0, "rd_reg3"};
    vecs[10] = '{1'b0, A_ID,     16'h4008, 1'b0, 5'd0, "rd_id_after_wr"};
    vecs[11] = '{1'b0, 14'h0030, 16'h0000, 1'b0, 5'd0, "rd_unmapped_hi"};
    vecs[12] = '{1'b0, 14'h000F, 16'h0000, 1'b0, 5'd0, "rd_unmapped_lo"};
    vecs[13] = '{1'b0, 14'h0011, 16'h0000, 1'b0, 5'd0, "rd_reg1"};
    vecs[14] = '{1'b1, A_MASK,   16'hFF7B, 1'b0, 5'd0, "wr_mask"};
    vecs[15] = '{1'b0, A_MASK,   16'h007B, 1'b0, 5'd0, "rd_mask_trunc"};
    vecs[16] = '{1'b1, A_MASK,   16'h00FF, 1'b0, 5'd0, "wr_mask_restore"};
    vecs[17] = '{1'b0, A_MASK,   16'h00FF, 1'b0, 5'd0, "rd_mask_restore"};

    repeat (3) @(negedge CLK);
    check("rst_ctrl_out", CTRL_OUT, '0);
    check("rst_wr_strobe", {127'd0, WR_STROBE}, 128'd0);
    check("rst_wr_index", {123'd0, WR_INDEX}, 128'd0);
    check("rst_xint", {127'd0, FAULT_XINT}, 128'd0);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      bus_read(14'h0010 + 14'(i), rd);
      check($sformatf("rst_rd_reg%0d", i), {112'd0, rd}, 128'd0);
    end
    bus_read(A_ID, rd);   check("rst_rd_id", {112'd0, rd}, 128'h4008);
    bus_read(A_FLT, rd);  check("rst_rd_latch", {112'd0, rd}, 128'h0000);
    bus_read(A_MASK, rd); check("rst_rd_mask", {112'd0, rd}, 128'h00FF);

`ifdef XINTF_WRITE_LOCK_EN
    bus_read(14'h001B, rd); check("rst_rd_lock", {112'd0, rd}, 128'd0);
    bus_write(14'h001B, 16'hA55A, 3);
    bus_read(14'h001B, rd); check("rd_unlocked", {112'd0, rd}, 128'd1);
`endif

    // long write strobe: one commit only
    s0 = strobes;
    bus_write(14'h0013, 16'h1234, 10);
    check("long_wr_strobes", 128'(strobes - s0), 128'd1);
    check("long_wr_index", {123'd0, last_idx}, 128'd3);
    check("long_wr_ctrl3", {112'd0, CTRL_OUT[63:48]}, 128'h1234);
    bus_read(14'h0013, rd);
    check("long_wr_readback", {112'd0, rd}, 128'h1234);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) begin
        s0 = strobes;
        bus_write(vecs[i].addr, vecs[i].data, 3);
        check({vecs[i].name, "_strobes"}, 128'(strobes - s0), vecs[i].strobe ? 128'd1 : 128'd0);
        if (vecs[i].strobe) check({vecs[i].name, "_index"}, {123'd0, last_idx}, {123'd0, vecs[i].idx});
      end else begin
        bus_read(vecs[i].addr, rd);
        check(vecs[i].name, {112'd0, rd}, {112'd0, vecs[i].data});
      end
    end
    check("ctrl_out_all", CTRL_OUT,
          {16'hFFFF, 16'h0000, 16'h0F0F, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 16'hA5A5});

    // fault on bit 2 for 5 cycles; XINT expected 4 cycles after the drop
    @(negedge CLK);
    FAULT_INPUT[2] = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      if (c == 5) FAULT_INPUT[2] = 1'b1;
      if (FAULT_XINT && lat == 0) lat = c;
    end
    check("fault_xint_latency", 128'(lat), 128'd4);
    bus_read(A_FLT, rd); check("fault_latch_rd", {112'd0, rd}, 128'h0004);
    bus_write(A_FLT, 16'h0004, 3);
    repeat (2) @(negedge CLK);
    check("fault_cleared_xint", {127'd0, FAULT_XINT}, 128'd0);
    bus_read(A_FLT, rd); check("fault_cleared_latch", {112'd0, rd}, 128'h0000);

    // masked fault
    bus_write(A_MASK, 16'h00FB, 3);
    FAULT_INPUT[2] = 1'b0;
    repeat (5) @(negedge CLK);
    FAULT_INPUT[2] = 1'b1;
    repeat (5) @(negedge CLK);
    check("masked_xint", {127'd0, FAULT_XINT}, 128'd0);
    bus_read(A_FLT, rd); check("masked_latch", {112'd0, rd}, 128'h0004);
    bus_write(A_MASK, 16'h00FF, 3);
    repeat (2) @(negedge CLK);
    check("unmasked_xint", {127'd0, FAULT_XINT}, 128'd1);
    bus_write(A_FLT, 16'h0004, 3);
    repeat (2) @(negedge CLK);
    check("unmasked_clear_xint", {127'd0, FAULT_XINT}, 128'd0);

    // clear while the fault is still present: set wins, XINT never drops
    FAULT_INPUT[1] = 1'b0;
    repeat (6) @(negedge CLK);
    check("held_fault_xint", {127'd0, FAULT_XINT}, 128'd1);
    xint_dropped = 1'b0;
    watch_xint = 1'b1;
    bus_write(A_FLT, 16'h0002, 3);
    repeat (3) @(negedge CLK);
    watch_xint = 1'b0;
    check("set_wins_no_drop", {127'd0, xint_dropped}, 128'd0);
    bus_read(A_FLT, rd); check("set_wins_latch", {112'd0, rd}, 128'h0002);
    FAULT_INPUT[1] = 1'b1;
    repeat (4) @(negedge CLK);
    bus_write(A_FLT, 16'h0002, 3);
    repeat (2) @(negedge CLK);
    check("released_clear_xint", {127'd0, FAULT_XINT}, 128'd0);
    bus_read(A_FLT, rd); check("released_clear_latch", {112'd0, rd}, 128'h0000);

`ifdef XINTF_WRITE_LOCK_EN
    bus_write(14'h001B, 16'h0000, 3);
    bus_read(14'h001B, rd); check("rd_locked", {112'd0, rd}, 128'd0);
    s0 = strobes;
    bus_write(14'h0010, 16'h5555, 3);
    check("locked_wr_strobes", 128'(strobes - s0), 128'd0);
    check("locked_wr_ctrl0", {112'd0, CTRL_OUT[15:0]}, 128'hA5A5);
    bus_write(14'h001B, 16'hA55A, 3);
    s0 = strobes;
    bus_write(14'h0010, 16'h5555, 3);
    check("unlocked_wr_strobes", 128'(strobes - s0), 128'd1);
    check("unlocked_wr_ctrl0", {112'd0, CTRL_OUT[15:0]}, 128'h5555);
`endif

    // reset during a write strobe aborts the write
    s0 = strobes;
    @(negedge CLK);
    Addr = 14'h0012; drv = 16'h7777; drv_en = 1'b1; CSn = 1'b0; WEn = 1'b0;
    repeat (4) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (3) @(negedge CLK);
    WEn = 1'b1; CSn = 1'b1;
    repeat (5) @(negedge CLK);
    drv_en = 1'b0;
    check("rst_abort_strobes", 128'(strobes - s0), 128'd0);
    check("rst_abort_ctrl", CTRL_OUT, '0);
`ifdef XINTF_WRITE_LOCK_EN
    bus_write(14'h001B, 16'hA55A, 3);
`endif
    s0 = strobes;
    bus_write(14'h0012, 16'h0BAD, 3);
    check("post_rst_wr_strobes", 128'(strobes - s0), 128'd1);
    check("post_rst_wr_ctrl2", {112'd0, CTRL_OUT[47:32]}, 128'h0BAD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
